etapa_wb_banco: RTL and testbench
=================================

// Module: etapa_wb_banco
// PURPOSE
//  Write-back stage of the vector pipeline; consumes MEM/WB pipeline-register outputs.
//  Selects the write-back data and commits it to the vector and scalar register banks.
//  Serves decode read ports with same-cycle bypass and gives EX a registered forward of the last write.
//  Counts committed writes for performance monitoring.
// PARAMETERS
//  NREG   8   registers per bank (vector and scalar)
//  AW     3   register address width, clog2(NREG)
//  VW     32  vector register width (4 lanes x 8 bit)
//  SW     8   scalar register width
//  CW     16  committed-write counter width
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst_n        in   1   asynchronous reset, active-low
//  sel_wb_in    in   1   1: write MEM_in, 0: write DATA_in to vector bank
//  reg_wrv_in   in   1   vector bank write enable
//  reg_wrs_in   in   1   scalar bank write enable
//  MEM_in       in   VW  data loaded from memory
//  DATA_in      in   VW  ALU result
//  dir_dest_in  in   AW  destination index (both banks)
//  data_wrs_in  in   SW  scalar write data
//  dir_va       in   AW  vector read port A address
//  dir_vb       in   AW  vector read port B address
//  dir_s        in   AW  scalar read port address
//  va_out       out  VW  vector read data A
//  vb_out       out  VW  vector read data B
//  s_out        out  SW  scalar read data
//  fwd_data     out  VW  registered copy of last vector write data
//  fwd_dir      out  AW  registered destination of that write
//  fwd_valid    out  1   fwd_data/fwd_dir valid (vector write happened last cycle)
//  cont_wb      out  CW  number of cycles with at least one committed write
// BEHAVIOUR
//  - Reset (rst_n=0, async): all V[i]=0, S[i]=0, fwd_data=0, fwd_dir=0, fwd_valid=0, cont_wb=0.
//    Reset asserted mid-write: write is lost and the register reads 0.
//    The first posedge after rst_n deasserts commits normally.
//  - wb_data = sel_wb_in ? MEM_in : DATA_in (combinational).
//  - Posedge, reg_wrv_in=1: V[dir_dest_in] <= wb_data. reg_wrs_in=1: S[dir_dest_in] <= data_wrs_in.
//    Both enables set: both banks written at the same index in the same cycle.
//    All registers writable (no hardwired zero).
//  - Reads are combinational with bypass: if reg_wrv_in && dir_va==dir_dest_in, va_out=wb_data, else V[dir_va].
//    vb_out follows the same rule. s_out bypasses data_wrs_in when reg_wrs_in && dir_s==dir_dest_in.
//    dir_va==dir_vb: both ports return identical data.
//  - Forward register (1-cycle latency):
//    fwd_valid <= reg_wrv_in.
//    If reg_wrv_in: fwd_data <= wb_data, fwd_dir <= dir_dest_in.
//    Otherwise fwd_data and fwd_dir hold their values.
//  - cont_wb <= cont_wb + 1 when (reg_wrv_in | reg_wrs_in); increment is 1 even with both enables set.
//    Wraps modulo 2^CW (0xFFFF -> 0x0000), no saturation.
//  - Enables are sampled at posedge only. X on an idle data input must not alter state.
// STRUCTURE
//  - Package wb_pkg: NREG/AW/VW/SW/CW constants, lane width LANE_W=8.
//  - Sub-module banco_reg_bypass #(W, NREG, NRD): array of NREG x W registers with async reset,
//    1 write port and NRD bypassed read ports.
//    Instantiated as vector bank (W=VW, NRD=2) and scalar bank (W=SW, NRD=1).
//  - Top level holds the wb_data mux, forward register and counter.
// TESTING
//  1 Reset: rst_n=0 with wr enables high -> all reads 0, fwd_valid=0, cont_wb=0.
//  2 sel_wb_in=1, MEM_in=0xA1B2C3D4, DATA_in=0x11111111, reg_wrv_in=1, dir_dest_in=5
//    -> next cycle V5=0xA1B2C3D4, fwd_valid=1, fwd_dir=5, cont_wb=1.
//  3 Bypass: same cycle as a write of 0x0000BEEF to V2, dir_va=dir_vb=2 -> va_out=vb_out=0x0000BEEF before the edge.
//    Scalar: write 0x7F to S3 with dir_s=3 -> s_out=0x7F before the edge.
//  4 Dual write: reg_wrv_in=reg_wrs_in=1, dir_dest_in=7, DATA_in=0xCAFEF00D, data_wrs_in=0x5A, sel_wb_in=0
//    -> V7=0xCAFEF00D, S7=0x5A, cont_wb increments by exactly 1.
//  5 Counter wrap: preload via 65535 write cycles, then one more write -> cont_wb=0x0000.
//    An idle cycle -> fwd_valid=0, fwd_data unchanged.
//  6 Async reset mid-stream: drop rst_n between edges after V4 written -> V4 reads 0 immediately,
//    with no clock edge needed.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the vector pipeline write-back stage and its register banks.
package wb_pkg;

    localparam int NREG   = 8;
    localparam int AW     = 3;
    localparam int VW     = 32;
    localparam int SW     = 8;
    localparam int CW     = 16;
    localparam int LANE_W = 8;
    localparam int NLANE  = VW / LANE_W;

endpackage

// File: rtl/banco_reg_bypass.sv
// Register bank with one write port and NRD combinational read ports.
// A read that hits the address being written this cycle returns the incoming data.
module banco_reg_bypass #(
    parameter int W    = 32,
    parameter int NREG = 8,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_dir,
    input  logic [W-1:0]            wr_data,
    input  logic [NRD-1:0][AW-1:0]  rd_dir,
    output logic [NRD-1:0][W-1:0]   rd_data
);

    logic [W-1:0] regs [NREG];

    // Storage: clear every register on reset, otherwise commit the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_dir] <= wr_data;
        end
    end

    // Read ports: stored value unless the same index is being written right now.
    always_comb begin
        for (int r = 0; r < NRD; r++) begin
            rd_data[r] = regs[rd_dir[r]];
            if (wr_en && (rd_dir[r] == wr_dir)) begin
                rd_data[r] = wr_data;
            end
        end
    end

endmodule

// File: rtl/etapa_wb_banco.sv
// Write-back stage: selects write-back data, commits it to the vector and scalar
// banks, forwards the last vector write to EX and counts cycles with a commit.
module etapa_wb_banco
    import wb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sel_wb_in,
    input  logic           reg_wrv_in,
    input  logic           reg_wrs_in,
    input  logic [VW-1:0]  MEM_in,
    input  logic [VW-1:0]  DATA_in,
    input  logic [AW-1:0]  dir_dest_in,
    input  logic [SW-1:0]  data_wrs_in,
    input  logic [AW-1:0]  dir_va,
    input  logic [AW-1:0]  dir_vb,
    input  logic [AW-1:0]  dir_s,
    output logic [VW-1:0]  va_out,
    output logic [VW-1:0]  vb_out,
    output logic [SW-1:0]  s_out,
    output logic [VW-1:0]  fwd_data,
    output logic [AW-1:0]  fwd_dir,
    output logic           fwd_valid,
    output logic [CW-1:0]  cont_wb
);

    logic [VW-1:0]         wb_data;
    logic [1:0][AW-1:0]    vrd_dir;
    logic [1:0][VW-1:0]    vrd_data;
    logic [0:0][AW-1:0]    srd_dir;
    logic [0:0][SW-1:0]    srd_data;

    // Write-back source: loaded memory word or ALU result.
    always_comb begin
        wb_data = sel_wb_in ? MEM_in : DATA_in;
    end

    // Pack the decode read addresses for the banks and unpack their data.
    always_comb begin
        vrd_dir[0] = dir_va;
        vrd_dir[1] = dir_vb;
        srd_dir[0] = dir_s;
        va_out     = vrd_data[0];
        vb_out     = vrd_data[1];
        s_out      = srd_data[0];
    end

    banco_reg_bypass #(
        .W    (VW),
        .NREG (NREG),
        .NRD  (2),
        .AW   (AW)
    ) u_banco_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (reg_wrv_in),
        .wr_dir  (dir_dest_in),
        .wr_data (wb_data),
        .rd_dir  (vrd_dir),
        .rd_data (vrd_data)
    );

    banco_reg_bypass #(
        .W    (SW),
        .NREG (NREG),
        .NRD  (1),
        .AW   (AW)
    ) u_banco_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (reg_wrs_in),
        .wr_dir  (dir_dest_in),
        .wr_data (data_wrs_in),
        .rd_dir  (srd_dir),
        .rd_data (srd_data)
    );

    // Forward register: remembers the last vector write, valid only the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_data  <= '0;
            fwd_dir   <= '0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= reg_wrv_in;
            if (reg_wrv_in) begin
                fwd_data <= wb_data;
                fwd_dir  <= dir_dest_in;
            end
        end
    end

    // Commit counter: one per cycle with any write, wrapping naturally at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_wb <= '0;
        end else if (reg_wrv_in || reg_wrs_in) begin
            cont_wb <= cont_wb + CW'(1);
        end
    end

endmodule

// File: tb/tb_etapa_wb_banco.sv
// Scoreboard bench for etapa_wb_banco: the driver predicts each cycle's outputs from
// a plain array model and queues them; the monitor compares after inputs settle.
module tb_etapa_wb_banco;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel_wb_in = 1'b0;
    logic        reg_wrv_in = 1'b0;
    logic        reg_wrs_in = 1'b0;
    logic [31:0] MEM_in = '0;
    logic [31:0] DATA_in = '0;
    logic [2:0]  dir_dest_in = '0;
    logic [7:0]  data_wrs_in = '0;
    logic [2:0]  dir_va = '0;
    logic [2:0]  dir_vb = '0;
    logic [2:0]  dir_s = '0;
    logic [31:0] va_out;
    logic [31:0] vb_out;
    logic [7:0]  s_out;
    logic [31:0] fwd_data;
    logic [2:0]  fwd_dir;
    logic        fwd_valid;
    logic [15:0] cont_wb;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [7:0]  s;
        logic [31:0] fd;
        logic [2:0]  fdir;
        logic        fv;
        logic [15:0] cnt;
    } exp_t;

    exp_t scoreboard[$];

    logic [31:0] mv [8];
    logic [7:0]  ms [8];
    logic [31:0] mfd;
    logic [2:0]  mfdir;
    logic        mfv;
    int          mcnt;

    int assertCount = 0;
    int failCount   = 0;
    bit driverDone  = 1'b0;

    etapa_wb_banco dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel_wb_in   (sel_wb_in),
        .reg_wrv_in  (reg_wrv_in),
        .reg_wrs_in  (reg_wrs_in),
        .MEM_in      (MEM_in),
        .DATA_in     (DATA_in),
        .dir_dest_in (dir_dest_in),
        .data_wrs_in (data_wrs_in),
        .dir_va      (dir_va),
        .dir_vb      (dir_vb),
        .dir_s       (dir_s),
        .va_out      (va_out),
        .vb_out      (vb_out),
        .s_out       (s_out),
        .fwd_data    (fwd_data),
        .fwd_dir     (fwd_dir),
        .fwd_valid   (fwd_valid),
        .cont_wb     (cont_wb)
    );

    // Free-running clock, posedge at 5 + 10k.
    always #5 clk = ~clk;

    // Clear the reference model to its reset contents.
    task automatic modelReset();
        for (int i = 0; i < 8; i++) begin
            mv[i] = '0;
            ms[i] = '0;
        end
        mfd   = '0;
        mfdir = '0;
        mfv   = 1'b0;
        mcnt  = 0;
    endtask

    // Drive one cycle at the negedge, queue the predicted outputs, advance the model.
    task automatic applyStimulus(input logic rst, input logic sel, input logic wrv,
                                 input logic wrs, input logic [31:0] mem,
                                 input logic [31:0] data, input logic [2:0] dest,
                                 input logic [7:0] sdata, input logic [2:0] a,
                                 input logic [2:0] b, input logic [2:0] sa);
        exp_t        e;
        logic [31:0] wb;
        @(negedge clk);
        rst_n       = rst;
        sel_wb_in   = sel;
        reg_wrv_in  = wrv;
        reg_wrs_in  = wrs;
        MEM_in      = mem;
        DATA_in     = data;
        dir_dest_in = dest;
        data_wrs_in = sdata;
        dir_va      = a;
        dir_vb      = b;
        dir_s       = sa;
        if (!rst) modelReset();
        wb     = sel ? mem : data;
        e.va   = (wrv && a == dest) ? wb : mv[a];
        e.vb   = (wrv && b == dest) ? wb : mv[b];
        e.s    = (wrs && sa == dest) ? sdata : ms[sa];
        e.fd   = mfd;
        e.fdir = mfdir;
        e.fv   = mfv;
        e.cnt  = 16'(mcnt);
        scoreboard.push_back(e);
        if (rst) begin
            if (wrv) begin
                mv[dest] = wb;
                mfd      = wb;
                mfdir    = dest;
            end
            if (wrs) ms[dest] = sdata;
            mfv = wrv;
            if (wrv || wrs) mcnt = (mcnt + 1) % 65536;
        end
    endtask

    // Idle cycle with undriven data inputs; only reads are exercised.
    task automatic applyIdle(input logic [2:0] a, input logic [2:0] b, input logic [2:0] sa);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 'x, 'x, 3'($urandom_range(0, 7)), 'x, a, b, sa);
    endtask

    // Random cycle; forceWrite guarantees at least one enable.
    task automatic applyRandom(input bit forceWrite);
        logic wrv;
        logic wrs;
        wrv = 1'($urandom_range(0, 1));
        wrs = 1'($urandom_range(0, 1));
        if (forceWrite && !wrv && !wrs) wrv = 1'b1;
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), wrv, wrs, $urandom, $urandom,
                      3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)));
    endtask

    // One scoreboard comparison.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: after inputs settle each cycle, pop the prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput("va_out",    va_out,    e.va);
                checkOutput("vb_out",    vb_out,    e.vb);
                checkOutput("s_out",     32'(s_out),   32'(e.s));
                checkOutput("fwd_data",  fwd_data,  e.fd);
                checkOutput("fwd_dir",   32'(fwd_dir), 32'(e.fdir));
                checkOutput("fwd_valid", 32'(fwd_valid), 32'(e.fv));
                checkOutput("cont_wb",   32'(cont_wb), 32'(e.cnt));
            end
        end
    end

    // Directed scenarios, random traffic, then the counter wrap.
    initial begin
        modelReset();
        $display("[TB] reset with write enables high");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom, 3'd1, 8'hEE, 3'd2, 3'd3, 3'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 3'd6, 8'h11, 3'd5, 3'd0, 3'd7);

        $display("[TB] memory write-back to V5");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hA1B2C3D4, 32'h11111111, 3'd5, 8'h00, 3'd0, 3'd1, 3'd0);
        applyIdle(3'd5, 3'd5, 3'd5);

        $display("[TB] bypass on vector and scalar ports");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000BEEF, 3'd2, 8'h00, 3'd2, 3'd2, 3'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 3'd3, 8'h7F, 3'd2, 3'd5, 3'd3);

        $display("[TB] dual write to index 7");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678, 32'hCAFEF00D, 3'd7, 8'h5A, 3'd0, 3'd0, 3'd0);
        applyIdle(3'd7, 3'd2, 3'd7);
        applyIdle(3'd3, 3'd5, 3'd3);

        $display("[TB] async reset between edges");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h44444444, 3'd4, 8'h00, 3'd4, 3'd4, 3'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 8'h00, 3'd4, 3'd7, 3'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h99999999, 3'd4, 8'h42, 3'd1, 3'd4, 3'd4);
        applyIdle(3'd4, 3'd4, 3'd4);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 8'h0,
                              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else if ($urandom_range(0, 4) == 0)
                applyIdle(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            else
                applyRandom(1'b0);
        end

        $display("[TB] counter wrap");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 8'h0, 3'd0, 3'd0, 3'd0);
        for (int i = 0; i < 65535; i++) applyRandom(1'b1);
        applyRandom(1'b1);
        applyIdle(3'd1, 3'd2, 3'd3);
        applyIdle(3'd4, 3'd5, 3'd6);
        driverDone = 1'b1;
    end

    // Wait for the scoreboard to drain with a bound, then summarise.
    initial begin
        int budget;
        wait (driverDone);
        budget = 20;
        while (scoreboard.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(negedge clk);
        #4;
        assertCount++;
        if (scoreboard.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", scoreboard.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time limit in case the driver stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
